// File: rtl/led_mirror_counter.sv
`default_nettype none
// ============================================================================
// Module : led_mirror_counter
// Debounced push-button up/down counter shown on two 7-segment digits, plus
// switch-to-LED mirroring that BT3 can freeze and release.
// Rev    : 1.0
// ============================================================================
module led_mirror_counter #(
  parameter int SW_W      = 10,
  parameter int DB_CYCLES = 16,
  parameter int CNT_MAX   = 99
) (
  input  logic            CLOCK_50,
  input  logic            RESET,
  input  logic [0:SW_W-1] V_SW,
  input  logic [3:0]      V_BT,
  output logic [0:SW_W-1] G_LED,
  output logic [0:6]      G_HEX0,
  output logic [0:6]      G_HEX1
);

  localparam int                c_DB_W      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [c_DB_W-1:0] c_DB_LAST   = c_DB_W'(DB_CYCLES - 1);
  localparam logic [6:0]        c_CNT_MAX   = 7'(CNT_MAX);
  localparam logic [6:0]        c_SEG_BLANK = 7'b1111111;

  typedef enum logic [0:0] {
    MODE_MIRROR = 1'b0,
    MODE_FREEZE = 1'b1
  } mode_t;

  logic [0:SW_W-1] r_sw_s1;
  logic [0:SW_W-1] r_sw_s2;
  logic [3:0]      r_bt_s1;
  logic [3:0]      r_bt_s2;
  logic [3:0]      w_press;
  mode_t           r_mode;
  mode_t           w_mode_nxt;
  logic [6:0]      r_cnt;
  logic [6:0]      w_cnt_nxt;
  logic [0:SW_W-1] r_led;
  logic [3:0]      w_ones;
  logic [3:0]      w_tens;

  // Two-flop synchronisers; reset parks everything at the released level.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_sw_s1 <= '1;
      r_sw_s2 <= '1;
      r_bt_s1 <= '1;
      r_bt_s2 <= '1;
    end else begin
      r_sw_s1 <= V_SW;
      r_sw_s2 <= r_sw_s1;
      r_bt_s1 <= V_BT;
      r_bt_s2 <= r_bt_s1;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_db
      logic              r_level;
      logic [c_DB_W-1:0] r_stab;
      logic              r_press;

      // Level flips once the input has disagreed for DB_CYCLES samples; a
      // flip away from 1 is a press, so the pulse is simply the old level.
      always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
          r_level <= 1'b1;
          r_stab  <= '0;
          r_press <= 1'b0;
        end else begin
          r_press <= 1'b0;
          if (r_bt_s2[gi] == r_level) begin
            r_stab <= '0;
          end else if (r_stab == c_DB_LAST) begin
            r_stab  <= '0;
            r_level <= r_bt_s2[gi];
            r_press <= r_level;
          end else begin
            r_stab <= r_stab + 1'b1;
          end
        end
      end

      assign w_press[gi] = r_press;
    end
  endgenerate

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_press[2]) begin
      w_cnt_nxt = '0;
    end else if (w_press[0] && !w_press[1]) begin
      w_cnt_nxt = (r_cnt == c_CNT_MAX) ? 7'd0 : r_cnt + 7'd1;
    end else if (w_press[1] && !w_press[0]) begin
      w_cnt_nxt = (r_cnt == 7'd0) ? c_CNT_MAX : r_cnt - 7'd1;
    end
  end

  always_comb begin
    w_mode_nxt = r_mode;
    if (w_press[3]) begin
      w_mode_nxt = (r_mode == MODE_MIRROR) ? MODE_FREEZE : MODE_MIRROR;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_cnt  <= '0;
      r_mode <= MODE_MIRROR;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_mode <= w_mode_nxt;
    end
  end

  // The LED register follows the current mode, so it still loads on the
  // edge that enters FREEZE and resumes one edge after returning to MIRROR.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_led <= '0;
    end else if (r_mode == MODE_MIRROR) begin
      r_led <= r_sw_s2;
    end
  end

  function automatic logic [6:0] f_seg7(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = c_SEG_BLANK;
    endcase
    return seg;
  endfunction

  assign w_ones = 4'(r_cnt % 7'd10);
  assign w_tens = 4'(r_cnt / 7'd10);

  assign G_LED  = r_led;
  assign G_HEX0 = f_seg7(w_ones);
  assign G_HEX1 = (r_cnt < 7'd10) ? c_SEG_BLANK : f_seg7(w_tens);

endmodule
`default_nettype wire

// File: tb/tb_led_mirror_counter.sv
`default_nettype none
// ============================================================================
// Module : tb_led_mirror_counter
// Scoreboard bench: a reference model queues expected outputs per clock edge
// and a monitor compares them; directed scenarios add fixed-value checks.
// Rev    : 1.0
// ============================================================================
module tb_led_mirror_counter;

  localparam int SW_W = 10;
  localparam int DB   = 4;
  localparam int MAXC = 99;

  typedef logic [0:SW_W-1] sw_t;
  typedef struct {
    logic [0:6] h0;
    logic [0:6] h1;
    sw_t        led;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  sw_t        sw;
  logic [3:0] bt;
  sw_t        led;
  logic [0:6] hex0;
  logic [0:6] hex1;

  always #5 clk = ~clk;

  led_mirror_counter #(
    .SW_W      (SW_W),
    .DB_CYCLES (DB),
    .CNT_MAX   (MAXC)
  ) u_dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .V_SW     (sw),
    .V_BT     (bt),
    .G_LED    (led),
    .G_HEX0   (hex0),
    .G_HEX1   (hex1)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];

  // Reference model state
  sw_t        m_sw_pipe[$];
  logic [3:0] m_bt_pipe[$];
  logic [3:0] m_lvl;
  int         m_run[4];
  logic [3:0] m_ev;
  int         m_count;
  bit         m_frozen;
  sw_t        m_led;
  sw_t        cur_sw;

  function automatic logic [0:6] seg(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [0:6] tens_seg(input int n);
    return (n < 10) ? 7'b1111111 : seg(n / 10);
  endfunction

  task automatic model_edge(input sw_t s, input logic [3:0] b, input bit r);
    sw_t        s_samp;
    logic [3:0] b_samp;
    logic [3:0] new_ev;
    if (r) begin
      m_sw_pipe = {};
      m_bt_pipe = {};
      repeat (2) begin
        m_sw_pipe.push_back('1);
        m_bt_pipe.push_back(4'hF);
      end
      m_lvl    = 4'hF;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_ev     = 4'h0;
      m_count  = 0;
      m_frozen = 1'b0;
      m_led    = '0;
      return;
    end
    s_samp = m_sw_pipe.pop_front();
    b_samp = m_bt_pipe.pop_front();
    m_sw_pipe.push_back(s);
    m_bt_pipe.push_back(b);
    if (m_ev[2])
      m_count = 0;
    else if (m_ev[0] && !m_ev[1])
      m_count = (m_count + 1) % (MAXC + 1);
    else if (m_ev[1] && !m_ev[0])
      m_count = (m_count + MAXC) % (MAXC + 1);
    if (!m_frozen) m_led = s_samp;
    if (m_ev[3]) m_frozen = !m_frozen;
    new_ev = 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (b_samp[i] == m_lvl[i]) begin
        m_run[i] = 0;
      end else begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_run[i]  = 0;
          new_ev[i] = m_lvl[i];
          m_lvl[i]  = b_samp[i];
        end
      end
    end
    m_ev = new_ev;
  endtask

  task automatic cyc(input sw_t s, input logic [3:0] b, input bit r);
    exp_t e;
    sw  = s;
    bt  = b;
    rst = r;
    @(posedge clk);
    model_edge(s, b, r);
    e.h0  = seg(m_count % 10);
    e.h1  = tens_seg(m_count);
    e.led = m_led;
    q.push_back(e);
    #1;
  endtask

  task automatic press(input logic [3:0] b);
    repeat (8)  cyc(cur_sw, b, 1'b0);
    repeat (10) cyc(cur_sw, 4'hF, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(cur_sw, 4'hF, 1'b0);
  endtask

  task automatic check_count(input string name, input int n);
    n_tests++;
    if (hex0 !== seg(n % 10) || hex1 !== tens_seg(n)) begin
      n_fail++;
      $display("FAIL %s: hex1/hex0 got %b/%b, expected %b/%b (count %0d)",
               name, hex1, hex0, tens_seg(n), seg(n % 10), n);
    end
  endtask

  task automatic check_led(input string name, input sw_t v);
    n_tests++;
    if (led !== v) begin
      n_fail++;
      $display("FAIL %s: G_LED got %b, expected %b", name, led, v);
    end
  endtask

  task automatic check_hex(input string name, input logic [0:6] a, input logic [0:6] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, a, e);
    end
  endtask

  // Monitor: one expected entry per clock edge, compared mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_tests++;
      if (hex0 !== e.h0 || hex1 !== e.h1 || led !== e.led) begin
        n_fail++;
        $display("FAIL scoreboard @%0t: hex1/hex0/led got %b/%b/%b, expected %b/%b/%b",
                 $time, hex1, hex0, led, e.h1, e.h0, e.led);
      end
    end
  end

  initial begin
    int cnt;
    cur_sw = '0;
    repeat (3) cyc(cur_sw, 4'hF, 1'b1);
    check_count("reset_hex", 0);
    check_hex("reset_hex1_blank", hex1, 7'b1111111);
    check_led("reset_led", '0);

    // Long hold gives exactly one increment
    repeat (20) cyc(cur_sw, 4'b1110, 1'b0);
    idle(12);
    check_hex("hold_hex0", hex0, 7'b1001111);
    check_count("hold_once", 1);

    // Bounce shorter than the debounce window is ignored
    for (int i = 0; i < 30; i++) cyc(cur_sw, ((i / 2) % 2) ? 4'hF : 4'hE, 1'b0);
    idle(12);
    check_count("bounce", 1);

    // Wrap both directions at the terminal value
    press(4'b1101);
    press(4'b1101);
    check_count("dec_wrap_0_to_99", 99);
    press(4'b1110);
    check_count("inc_wrap_99_to_0", 0);
    press(4'b1101);
    check_hex("wrap_hex1", hex1, 7'b0000100);
    check_hex("wrap_hex0", hex0, 7'b0000100);

    // Clear wins over inc/dec; inc+dec together cancel
    press(4'b1110);
    for (int i = 0; i < 37; i++) press(4'b1110);
    check_count("reach_37", 37);
    press(4'b1000);
    check_count("clear_priority", 0);
    for (int i = 0; i < 5; i++) press(4'b1110);
    press(4'b1100);
    check_count("inc_dec_cancel", 5);

    // Mirror latency, freeze, release
    cur_sw = 10'b1010101010;
    repeat (2) cyc(cur_sw, 4'hF, 1'b0);
    check_led("mirror_not_yet", '0);
    cyc(cur_sw, 4'hF, 1'b0);
    check_led("mirror_3cyc", 10'b1010101010);
    press(4'b0111);
    cur_sw = '0;
    idle(6);
    check_led("freeze_hold", 10'b1010101010);
    press(4'b0111);
    check_led("unfreeze", '0);

    // Reset while BT1 held at 12; held press registers DB+3 cycles later
    for (int i = 0; i < 7; i++) press(4'b1110);
    check_count("reach_12", 12);
    cur_sw = 10'b1100110011;
    idle(4);
    press(4'b0111);
    repeat (3) cyc(cur_sw, 4'b1101, 1'b0);
    repeat (2) cyc(cur_sw, 4'b1101, 1'b1);
    check_count("reset_mid_press", 0);
    check_led("reset_mid_press_led", '0);
    repeat (DB + 2) cyc(cur_sw, 4'b1101, 1'b0);
    check_count("held_not_yet", 0);
    cyc(cur_sw, 4'b1101, 1'b0);
    check_count("held_after_reset", 99);
    idle(12);

    // Randomised buttons and switches checked only by the scoreboard
    for (int k = 0; k < 80; k++) begin
      logic [3:0] m;
      m = 4'($urandom);
      repeat ($urandom_range(1, 10)) cyc(sw_t'($urandom), m, 1'b0);
      if (k == 40) repeat ($urandom_range(1, 2)) cyc(sw_t'($urandom), m, 1'b1);
      repeat ($urandom_range(1, 10)) cyc(sw_t'($urandom), 4'hF, 1'b0);
    end
    cnt = m_count;
    idle(12);
    check_count("random_final", cnt);

    repeat (2) @(negedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_mirror_counter.md
LED_MIRROR_COUNTER -- requirements
Module: led_mirror_counter

Interface
REQ-001 The module SHALL have parameter SW_W, default 10: switch and LED width.
REQ-002 The module SHALL have parameter DB_CYCLES, default 16: debounce stability count, minimum 1.
REQ-003 The module SHALL have parameter CNT_MAX, default 99: counter terminal value, range 1..99.
REQ-004 The module SHALL have port CLOCK_50  in  1  the single system clock; all state SHALL change on its rising edge.
REQ-005 The module SHALL have port RESET  in  1  reset; synchronous and active-high.
REQ-006 The module SHALL have port V_SW  in  [0:SW_W-1]  slide switches, asynchronous to CLOCK_50.
REQ-007 The module SHALL have port V_BT  in  [3:0]  push buttons, active-low (0 = pressed), asynchronous.
REQ-008 The module SHALL have port G_LED  out  [0:SW_W-1]  LEDs, active-high.
REQ-009 The module SHALL have port G_HEX0  out  [0:6]  ones digit, segments a..g at indices 0..6, active-low.
REQ-010 The module SHALL have port G_HEX1  out  [0:6]  tens digit, same encoding as G_HEX0.

Function
REQ-011 Every V_SW and V_BT bit SHALL pass through a two-flop synchroniser before any use.
REQ-012 Each synchronised button SHALL have its own debouncer holding a debounced level and a stability counter.
REQ-013 The debounced level SHALL take the synchronised value on the cycle after that value has differed from it for DB_CYCLES consecutive cycles; any return to agreement SHALL clear the stability counter.
REQ-014 A press event SHALL be a one-cycle pulse on a 1->0 transition of a debounced level; release SHALL generate no event.
REQ-015 The counter SHALL be an unsigned value in 0..CNT_MAX that is updated on the cycle after a press event.
REQ-016 A BT0 press SHALL increment the counter, wrapping from CNT_MAX to 0.
REQ-017 A BT1 press SHALL decrement the counter, wrapping from 0 to CNT_MAX.
REQ-018 A BT2 press SHALL clear the counter to 0 and SHALL take priority over BT0/BT1 events in the same cycle.
REQ-019 Simultaneous BT0 and BT1 events without BT2 SHALL leave the counter unchanged.
REQ-020 A BT3 press SHALL toggle the LED mode between MIRROR and FREEZE; it SHALL be independent of the counter and may coincide with counter events.
REQ-021 In MIRROR, the G_LED register SHALL load the synchronised V_SW every cycle, for a total latency of 3 cycles from V_SW to G_LED.
REQ-022 On entry to FREEZE, G_LED SHALL hold its current value until return to MIRROR; mirroring SHALL resume on the next cycle.
REQ-023 G_HEX0 SHALL show counter mod 10 and G_HEX1 SHALL show counter / 10, decoded combinationally from the counter register with no additional latency.
REQ-024 Decode SHALL use these patterns: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
REQ-025 G_HEX1 SHALL show blank (1111111) when the counter is below 10.

Reset
REQ-026 While RESET=1 at a clock edge, the module SHALL clear the counter to 0, set mode to MIRROR and clear G_LED to all 0.
REQ-027 While RESET=1 at a clock edge, all synchronisers and debounced levels SHALL be set to 1 (released), and all stability counters SHALL be cleared.
REQ-028 After reset, G_HEX0 SHALL read 0000001 and G_HEX1 SHALL read 1111111.
REQ-029 A reset asserted mid-debounce or mid-press SHALL discard the pending event; a button held through reset release SHALL register one press DB_CYCLES+3 cycles later.

Verification (DB_CYCLES=4, CNT_MAX=99)
REQ-030 Scenario: hold V_BT=1110 for 20 cycles -> exactly one increment, counter 0->1, G_HEX0=1001111.
REQ-031 Scenario: toggle BT0 low/high every 2 cycles for 30 cycles, then release -> counter unchanged.
REQ-032 Scenario: preload counter 99 and press BT0 -> counter 0; press BT1 -> counter 99, G_HEX1=0000100, G_HEX0=0000100.
REQ-033 Scenario: press BT0, BT1 and BT2 together at counter 37 -> counter 0; press BT0 and BT1 together at counter 5 -> counter stays 5.
REQ-034 Scenario: set V_SW=1010101010 -> G_LED matches after 3 cycles; press BT3, change V_SW to 0 -> G_LED holds; press BT3 -> G_LED=0.
REQ-035 Scenario: assert RESET during a held BT1 at counter 12 -> counter 0, MIRROR mode, G_LED=0; with BT1 still held after release -> counter 99.
